// File: rtl/alu_op_issuer.sv
// Command FIFO plus issue FSM driving a fixed-latency ALU and returning results in order.
// Optional `ALU_ISSUER_TAG_EN adds an 8-bit per-command tag returned on rsp_tag.
module alu_op_issuer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [OPW-1:0]   rsp_op,
`ifdef ALU_ISSUER_TAG_EN
  output logic [7:0]       rsp_tag,
`endif
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(ALU_LAT + 1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [CW-1:0] LatCnt  = CW'(ALU_LAT);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full, empty, capture;

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [OPW-1:0]   mem_op [DEPTH];

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  // Registered count only: a pop does not reopen cmd_ready in the same cycle.
  assign cmd_ready = reset & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == StIdle) & ~empty;
  assign busy      = ~empty | (state_q != StIdle);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StWait;
          cnt_d   = LatCnt;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StResp;
          capture = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr_q]  <= cmd_a;
      mem_b[wptr_q]  <= cmd_b;
      mem_op[wptr_q] <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PtrOne;
      // Operands stay on the bus after issue until the next pop.
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
        alu_a  <= mem_a[rptr_q];
        alu_b  <= mem_b[rptr_q];
        alu_op <= mem_op[rptr_q];
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_op     <= alu_op;
      end else if ((state_q == StResp) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUER_TAG_EN
  logic [7:0] tag_q, issue_tag_q;
  logic [7:0] mem_tag [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_tag[wptr_q] <= tag_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q       <= '0;
      issue_tag_q <= '0;
      rsp_tag     <= '0;
    end else begin
      if (push)    tag_q       <= tag_q + 8'd1;
      if (pop)     issue_tag_q <= mem_tag[rptr_q];
      if (capture) rsp_tag     <= issue_tag_q;
    end
  end
`endif

endmodule
